wb_lsu_master: RTL and testbench

Load/store unit that turns single CPU memory requests into pipelined Wishbone master transfers, directly upstream of `main_memory`. Generates byte-lane selects and store-data replication from RISC-V funct3 and the byte address, waits out slave stalls and acknowledges, and returns sign- or zero-extended load data. Misalignment, illegal funct3 and missing acknowledges are reported as errors.

---
 rtl/lsu_pkg.sv | 57 +++++
 rtl/lsu_lane_align.sv | 25 ++
 rtl/wb_lsu_master.sv | 162 ++++++++++++++++
 tb/tb_wb_lsu_master.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, state type and lane helpers for the Wishbone load/store unit.
// Lane placement and request checks live here so the FSM and the aligner agree.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_t;

    function automatic logic [3:0] lane_sel(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] sel;
        case (funct3)
            F3_B, F3_BU: sel = 4'b0001 << off;
            F3_H, F3_HU: sel = 4'b0011 << off;
            default:     sel = 4'b1111;
        endcase
        return sel;
    endfunction

    // Word loads are always aligned here, so the shifted word equals the raw word.
    function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [31:0] ext;
        shifted = word >> {off, 3'b000};
        case (funct3)
            F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ext = {24'h0, shifted[7:0]};
            F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
        return ext;
    endfunction

    function automatic logic req_error(input logic we, input logic [2:0] funct3, input logic [1:0] off);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = |off;
            F3_BU:   bad = we;
            F3_HU:   bad = we | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: select mask, replicated store data and
// sign/zero-extended load data for one access.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        sel_o   = lane_sel(funct3_i, off_i);
        rdata_o = load_extend(funct3_i, off_i, rword_i);
        case (funct3_i)
            F3_B:    wdata_o = {4{wdata_i[7:0]}};
            F3_H:    wdata_o = {2{wdata_i[15:0]}};
            default: wdata_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// Single-request load/store unit driving a pipelined Wishbone master port.
// One transfer in flight; stalls, missing acks and bad requests end in a response.
module wb_lsu_master
    import lsu_pkg::*;
#(
    parameter int  MEMORY_DEPTH = 1024,
    parameter int  TIMEOUT      = 16,
    localparam int ADDR_W       = $clog2(MEMORY_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [31:0]       o_wb_data,
    output logic [3:0]        o_wb_sel,
    input  logic              i_wb_ack,
    input  logic              i_wb_stall,
    input  logic [31:0]       i_wb_data
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rword_q, rword_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        sel;
    logic [31:0]       wdata_rep;
    logic [31:0]       rdata_ext;

    // Address bits above the slave's word range wrap by design.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^i_req_addr[31:ADDR_W+2];

    lsu_lane_align u_align (
        .funct3_i (f3_q),
        .off_i    (off_q),
        .wdata_i  (wdata_q),
        .rword_i  (rword_q),
        .sel_o    (sel),
        .wdata_o  (wdata_rep),
        .rdata_o  (rdata_ext)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            waddr_q <= '0;
            wdata_q <= 32'h0;
            rword_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rword_q <= rword_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        rword_d     = rword_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_err   = 1'b0;
        o_rsp_rdata = 32'h0;
        o_wb_cyc    = 1'b0;
        o_wb_stb    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    f3_d    = i_req_funct3;
                    off_d   = i_req_addr[1:0];
                    waddr_d = i_req_addr[ADDR_W+1:2];
                    wdata_d = i_req_wdata;
                    rword_d = 32'h0;
                    err_d   = req_error(i_req_we, i_req_funct3, i_req_addr[1:0]);
                    state_d = err_d ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                // An ack while stalled cannot belong to this strobe.
                if (!i_wb_stall) begin
                    if (i_wb_ack) begin
                        rword_d = i_wb_data;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                o_wb_cyc = 1'b1;
                if (i_wb_ack) begin
                    rword_d = i_wb_data;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = err_q;
                if (!err_q && !we_q) begin
                    o_rsp_rdata = rdata_ext;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus fields are quiet whenever no cycle is open.
    assign o_wb_we   = o_wb_cyc & we_q;
    assign o_wb_addr = o_wb_cyc ? waddr_q : '0;
    assign o_wb_data = o_wb_cyc ? wdata_rep : 32'h0;
    assign o_wb_sel  = o_wb_cyc ? sel : 4'h0;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Scoreboard bench for wb_lsu_master with a scripted Wishbone slave and word memory.
module tb_wb_lsu_master;

    localparam int MEMORY_DEPTH = 1024;
    localparam int TIMEOUT      = 16;
    localparam int ADDR_W       = $clog2(MEMORY_DEPTH);

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [2:0]        i_req_funct3;
    logic [31:0]       i_req_addr;
    logic [31:0]       i_req_wdata;
    logic              o_rsp_valid;
    logic [31:0]       o_rsp_rdata;
    logic              o_rsp_err;
    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic              o_wb_we;
    logic [ADDR_W-1:0] o_wb_addr;
    logic [31:0]       o_wb_data;
    logic [3:0]        o_wb_sel;
    logic              i_wb_ack;
    logic              i_wb_stall;
    logic [31:0]       i_wb_data;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem [0:MEMORY_DEPTH-1];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rdata, last_wbdata;
    logic [3:0]  last_sel;
    logic [31:0] last_waddr;
    logic        last_we, last_err;
    int          last_lat;

    wb_lsu_master #(.MEMORY_DEPTH(MEMORY_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .o_wb_we      (o_wb_we),
        .o_wb_addr    (o_wb_addr),
        .o_wb_data    (o_wb_data),
        .o_wb_sel     (o_wb_sel),
        .i_wb_ack     (i_wb_ack),
        .i_wb_stall   (i_wb_stall),
        .i_wb_data    (i_wb_data)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'd0:    return 1'b0;
            3'd1:    return off[0];
            3'd2:    return off != 2'b00;
            3'd4:    return we;
            3'd5:    return we || off[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] model_sel(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'd0, 3'd4: return 4'(1 << off);
            3'd1, 3'd5: return off[1] ? 4'hC : 4'h3;
            default:    return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_rep(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            3'd0:    return 32'(wdata[7:0]) * 32'h01010101;
            3'd1:    return 32'(wdata[15:0]) * 32'h00010001;
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
        int          v;
        logic [31:0] s;
        s = word >> (8 * off);
        case (f3)
            3'd0: begin
                v = int'(s[7:0]);
                if (v > 127) v = v - 256;
            end
            3'd4: v = int'(s[7:0]);
            3'd1: begin
                v = int'(s[15:0]);
                if (v > 32767) v = v - 65536;
            end
            3'd5:    v = int'(s[15:0]);
            default: v = int'(word);
        endcase
        return 32'(v);
    endfunction

    task automatic slave_ack();
        i_wb_ack  = 1'b1;
        i_wb_data = mem[o_wb_addr];
        if (o_wb_we) begin
            for (int b = 0; b < 4; b++) begin
                if (o_wb_sel[b]) mem[o_wb_addr][8*b +: 8] = o_wb_data[8*b +: 8];
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_val({name, ".ready"},  32'(o_req_ready), 32'h1);
        check_val({name, ".rvalid"}, 32'(o_rsp_valid), 32'h0);
        check_val({name, ".rerr"},   32'(o_rsp_err),   32'h0);
        check_val({name, ".rdata"},  o_rsp_rdata,      32'h0);
        check_val({name, ".cyc"},    32'(o_wb_cyc),    32'h0);
        check_val({name, ".stb"},    32'(o_wb_stb),    32'h0);
        check_val({name, ".we"},     32'(o_wb_we),     32'h0);
        check_val({name, ".addr"},   32'(o_wb_addr),   32'h0);
        check_val({name, ".data"},   o_wb_data,        32'h0);
        check_val({name, ".sel"},    32'(o_wb_sel),    32'h0);
    endtask

    // Called at a negedge with the block idle; returns at a negedge with it idle again.
    task automatic run_txn(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int stalls, input int ackdly, input bit noack);
        exp_t              e;
        exp_t              got_e;
        logic [ADDR_W-1:0] wa;
        logic              bad;
        int                acc_k;
        int                st_left;
        bit                got;
        wa      = addr[ADDR_W+1:2];
        bad     = model_err(we, f3, addr[1:0]);
        e.err   = bad || noack;
        e.rdata = (e.err || we) ? 32'h0 : model_ext(f3, addr[1:0], mem[wa]);
        e.lat   = bad ? 1 : (noack ? stalls + TIMEOUT + 2 : stalls + ackdly + 2);
        sbq.push_back(e);

        check_val({name, ".ready"}, 32'(o_req_ready), 32'h1);
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        @(posedge i_clk);
        acc_k   = -1;
        st_left = stalls;
        got     = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge i_clk);
            i_req_valid = 1'b0;
            i_wb_stall  = 1'b0;
            i_wb_ack    = 1'b0;
            i_wb_data   = 32'h0;
            if (bad) check_val({name, ".no_cyc"}, 32'(o_wb_cyc), 32'h0);
            if (o_rsp_valid) begin
                got = 1'b1;
                check_val({name, ".sb_nonempty"}, 32'(sbq.size() != 0), 32'h1);
                if (sbq.size() != 0) begin
                    got_e = sbq.pop_front();
                    check_val({name, ".err"},   32'(o_rsp_err), 32'(got_e.err));
                    check_val({name, ".rdata"}, o_rsp_rdata,    got_e.rdata);
                    check_val({name, ".lat"},   32'(k),         32'(got_e.lat));
                end
                check_val({name, ".rsp_cyc"}, 32'(o_wb_cyc), 32'h0);
                last_rdata = o_rsp_rdata;
                last_err   = o_rsp_err;
                last_lat   = k;
            end else if (o_wb_stb) begin
                check_val({name, ".cyc"},  32'(o_wb_cyc),  32'h1);
                check_val({name, ".sel"},  32'(o_wb_sel),  32'(model_sel(f3, addr[1:0])));
                check_val({name, ".addr"}, 32'(o_wb_addr), 32'(wa));
                check_val({name, ".we"},   32'(o_wb_we),   32'(we));
                if (we) check_val({name, ".wdata"}, o_wb_data, model_rep(f3, wdata));
                last_sel    = o_wb_sel;
                last_waddr  = 32'(o_wb_addr);
                last_we     = o_wb_we;
                last_wbdata = o_wb_data;
                if (st_left > 0) begin
                    i_wb_stall = 1'b1;
                    st_left--;
                end else begin
                    acc_k = k;
                    if (!noack && ackdly == 0) slave_ack();
                end
            end else if (o_wb_cyc) begin
                if (!noack && acc_k >= 0 && k - acc_k == ackdly) slave_ack();
            end
        end
        check_val({name, ".rsp_seen"}, 32'(got), 32'h1);
        @(negedge i_clk);
        check_val({name, ".pulse"},    32'(o_rsp_valid), 32'h0);
        check_val({name, ".idle_rdy"}, 32'(o_req_ready), 32'h1);
        check_val({name, ".idle_cyc"}, 32'(o_wb_cyc),    32'h0);
    endtask

    initial begin
        logic [2:0]  f3s [5];
        logic [2:0]  f3r;
        logic        wer;
        logic [31:0] ar;
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < MEMORY_DEPTH; i++) mem[i] = {16'(i) ^ 16'h8C3A, 16'(i * 7)};

        i_rst        = 1'b1;
        i_req_valid  = 1'b0;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b000;
        i_req_addr   = 32'h0;
        i_req_wdata  = 32'h0;
        i_wb_ack     = 1'b0;
        i_wb_stall   = 1'b0;
        i_wb_data    = 32'h0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("rst");
        i_rst = 1'b0;
        @(negedge i_clk);

        run_txn("sw0", 1'b1, 3'b010, 32'h0, 32'hAABBCCDD, 0, 0, 1'b0);
        check_val("sw0.sel_c",   32'(last_sel), 32'hF);
        check_val("sw0.addr_c",  last_waddr,    32'h0);
        check_val("sw0.we_c",    32'(last_we),  32'h1);
        check_val("sw0.lat_c",   32'(last_lat), 32'd2);

        run_txn("lb3", 1'b0, 3'b000, 32'h3, 32'h0, 0, 0, 1'b0);
        check_val("lb3.sel_c",   32'(last_sel), 32'h8);
        check_val("lb3.rdata_c", last_rdata,    32'hFFFFFFAA);
        run_txn("lbu3", 1'b0, 3'b100, 32'h3, 32'h0, 0, 0, 1'b0);
        check_val("lbu3.sel_c",   32'(last_sel), 32'h8);
        check_val("lbu3.rdata_c", last_rdata,    32'h000000AA);

        run_txn("sh6", 1'b1, 3'b001, 32'h6, 32'h00001234, 0, 1, 1'b0);
        check_val("sh6.data_c", last_wbdata,   32'h12341234);
        check_val("sh6.sel_c",  32'(last_sel), 32'hC);
        check_val("sh6.addr_c", last_waddr,    32'h1);
        run_txn("lhu6", 1'b0, 3'b101, 32'h6, 32'h0, 0, 0, 1'b0);
        check_val("lhu6.rdata_c", last_rdata, 32'h00001234);

        run_txn("sb9", 1'b1, 3'b000, 32'h9, 32'hFFFFFF80, 0, 0, 1'b0);
        run_txn("lb9", 1'b0, 3'b000, 32'h9, 32'h0, 1, 0, 1'b0);
        check_val("lb9.rdata_c", last_rdata, 32'hFFFFFF80);
        run_txn("lh4", 1'b0, 3'b001, 32'h4, 32'h0, 0, 0, 1'b0);

        run_txn("lw_stall", 1'b0, 3'b010, 32'h10, 32'h0, 3, 2, 1'b0);
        check_val("lw_stall.lat_c", 32'(last_lat), 32'd7);
        check_val("lw_stall.err_c", 32'(last_err), 32'h0);

        run_txn("lw_mis", 1'b0, 3'b010, 32'h2, 32'h0, 0, 0, 1'b0);
        check_val("lw_mis.err_c", 32'(last_err), 32'h1);
        check_val("lw_mis.lat_c", 32'(last_lat), 32'd1);
        run_txn("f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 0, 0, 1'b0);
        check_val("f3_011.err_c", 32'(last_err), 32'h1);
        run_txn("f3_110", 1'b1, 3'b110, 32'h0, 32'h0, 0, 0, 1'b0);
        run_txn("sbu", 1'b1, 3'b100, 32'h0, 32'h0, 0, 0, 1'b0);
        run_txn("sh_mis", 1'b1, 3'b001, 32'h5, 32'h0, 0, 0, 1'b0);

        run_txn("tmo", 1'b0, 3'b010, 32'h8, 32'h0, 0, 0, 1'b1);
        check_val("tmo.err_c", 32'(last_err), 32'h1);
        check_val("tmo.lat_c", 32'(last_lat), 32'(TIMEOUT + 2));

        run_txn("wrap", 1'b0, 3'b010, 32'h1000, 32'h0, 0, 0, 1'b0);
        check_val("wrap.addr_c",  last_waddr, 32'h0);
        check_val("wrap.rdata_c", last_rdata, 32'hAABBCCDD);

        // Stray ack while idle must not produce a response.
        i_wb_ack  = 1'b1;
        i_wb_data = 32'h12345678;
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        check_val("stray.rvalid", 32'(o_rsp_valid), 32'h0);
        check_val("stray.ready",  32'(o_req_ready), 32'h1);
        @(negedge i_clk);

        for (int i = 0; i < 20; i++) begin
            wer = 1'($urandom_range(0, 1));
            f3r = wer ? f3s[$urandom_range(0, 2)] : f3s[$urandom_range(0, 4)];
            ar  = $urandom;
            if (f3r == 3'd1 || f3r == 3'd5) ar[0] = 1'b0;
            if (f3r == 3'd2) ar[1:0] = 2'b00;
            run_txn($sformatf("rnd%0d", i), wer, f3r, ar, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end

        // Reset while waiting for an ack releases the bus with no response.
        check_val("rstw.ready0", 32'(o_req_ready), 32'h1);
        i_req_valid  = 1'b1;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h20;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check_val("rstw.stb", 32'(o_wb_stb), 32'h1);
        @(negedge i_clk);
        check_val("rstw.wait_cyc", 32'(o_wb_cyc), 32'h1);
        check_val("rstw.wait_stb", 32'(o_wb_stb), 32'h0);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("rstw");
        i_rst = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            check_val("rstw.no_rsp", 32'(o_rsp_valid), 32'h0);
        end

        check_val("sb_empty", 32'(sbq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
